// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, function codes,
// FSM state and ALU operation encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        SLT = 3'd4
    } alu_op_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational integer ALU; arithmetic wraps modulo 2^XLEN, SLT is signed.
module mips_alu
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (op)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            SLT:     result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS integer core: FETCH (valid/ready handshake), EXEC, WB.
// Owns the PC and register file; reports each completed instruction on retire.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] retire_pc,
    output logic            retire_wen,
    output logic [4:0]      retire_widx,
    output logic [XLEN-1:0] retire_wdata,
    output logic            illegal
);

    localparam int IDXW = $clog2(NREGS);

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [31:0]     ir_reg;
    logic [XLEN-1:0] alu_q_reg;
    logic [XLEN-1:0] next_pc_reg;
    logic            wen_reg;
    logic [4:0]      widx_reg;
    logic            illegal_reg;
    logic [XLEN-1:0] ret_pc_reg;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        unused_shamt;

    assign opcode       = ir_reg[31:26];
    assign rs           = ir_reg[25:21];
    assign rt           = ir_reg[20:16];
    assign rd           = ir_reg[15:11];
    assign funct        = ir_reg[5:0];
    assign imm          = ir_reg[15:0];
    assign unused_shamt = ^ir_reg[10:6];

    // Register file: index 0 is hardwired zero, indices >= NREGS do not exist.
    logic [XLEN-1:0] rf [NREGS];
    logic            rs_ok;
    logic            rt_ok;
    logic            wr_ok;
    logic            rf_we;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    generate
        if (IDXW < 5) begin : g_idx_narrow
            assign rs_ok = (rs[4:IDXW] == '0);
            assign rt_ok = (rt[4:IDXW] == '0);
            assign wr_ok = (widx_reg[4:IDXW] == '0);
        end else begin : g_idx_full
            assign rs_ok = 1'b1;
            assign rt_ok = 1'b1;
            assign wr_ok = 1'b1;
        end
    endgenerate

    assign rs_val = rs_ok ? rf[rs[IDXW-1:0]] : '0;
    assign rt_val = rt_ok ? rf[rt[IDXW-1:0]] : '0;
    assign rf_we  = (state_reg == WB) && wen_reg && wr_ok && (widx_reg != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] q_reg;
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        q_reg <= '0;
                    end else if (rf_we && (widx_reg[IDXW-1:0] == IDXW'(gi))) begin
                        q_reg <= alu_q_reg;
                    end
                end
                assign rf[gi] = q_reg;
            end
        end
    endgenerate

    // Decode
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            dec_wen;
    logic [4:0]      dec_widx;
    logic            dec_illegal;
    logic            is_beq;
    logic            is_bne;
    logic            is_jr;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc_next;

    assign imm_sext = XLEN'($signed(imm));
    assign pc_plus4 = pc_reg + XLEN'(4);

    always_comb begin
        alu_op      = ADD;
        alu_b       = rt_val;
        dec_wen     = 1'b0;
        dec_widx    = rd;
        dec_illegal = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_jr       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin alu_op = ADD; dec_wen = 1'b1; end
                    FN_SUB:  begin alu_op = SUB; dec_wen = 1'b1; end
                    FN_AND:  begin alu_op = AND; dec_wen = 1'b1; end
                    FN_OR:   begin alu_op = OR;  dec_wen = 1'b1; end
                    FN_SLT:  begin alu_op = SLT; dec_wen = 1'b1; end
                    FN_JR:   is_jr = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_b    = imm_sext;
                dec_wen  = 1'b1;
                dec_widx = rt;
            end
            OP_BEQ: begin
                alu_op = SUB;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                alu_op = SUB;
                is_bne = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    mips_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Branch comparison reuses the ALU's SUB result: zero means rs == rt.
    always_comb begin
        next_pc_next = pc_plus4;
        if ((is_beq && alu_zero) || (is_bne && !alu_zero)) begin
            next_pc_next = pc_plus4 + (imm_sext << 2);
        end else if (is_jr) begin
            next_pc_next = {rs_val[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            alu_q_reg   <= '0;
            next_pc_reg <= '0;
            wen_reg     <= 1'b0;
            widx_reg    <= '0;
            illegal_reg <= 1'b0;
            ret_pc_reg  <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_valid) begin
                        ir_reg    <= imem_rdata;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    alu_q_reg   <= alu_result;
                    next_pc_reg <= next_pc_next;
                    wen_reg     <= dec_wen;
                    widx_reg    <= dec_widx;
                    illegal_reg <= dec_illegal;
                    ret_pc_reg  <= pc_reg;
                    state_reg   <= WB;
                end
                WB: begin
                    pc_reg    <= next_pc_reg;
                    state_reg <= FETCH;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    // Retire fields are loaded once per instruction and hold between pulses.
    assign imem_req     = (state_reg == FETCH) && !reset;
    assign imem_addr    = pc_reg;
    assign retire       = (state_reg == WB);
    assign retire_pc    = ret_pc_reg;
    assign retire_wen   = wen_reg;
    assign retire_widx  = widx_reg;
    assign retire_wdata = alu_q_reg;
    assign illegal      = retire && illegal_reg;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench: directed vector table, randomized program against an
// instruction-level reference model, reset-in-EXEC and NREGS=8 corner cases.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        retire;
    logic [31:0] retire_pc;
    logic        retire_wen;
    logic [4:0]  retire_widx;
    logic [31:0] retire_wdata;
    logic        illegal;

    logic        imem_req8;
    logic [31:0] imem_addr8;
    logic        imem_valid8;
    logic [31:0] imem_rdata8;
    logic        retire8;
    logic [31:0] retire_pc8;
    logic        retire_wen8;
    logic [4:0]  retire_widx8;
    logic [31:0] retire_wdata8;
    logic        illegal8;

    always #5 clk = ~clk;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .retire(retire), .retire_pc(retire_pc), .retire_wen(retire_wen),
        .retire_widx(retire_widx), .retire_wdata(retire_wdata), .illegal(illegal)
    );

    mips_multicycle_core #(.XLEN(32), .NREGS(8), .RESET_PC(32'h40)) dut8 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req8), .imem_addr(imem_addr8),
        .imem_valid(imem_valid8), .imem_rdata(imem_rdata8),
        .retire(retire8), .retire_pc(retire_pc8), .retire_wen(retire_wen8),
        .retire_widx(retire_widx8), .retire_wdata(retire_wdata8), .illegal(illegal8)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Instruction-level reference model (NREGS=32)
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : m_regs[i];
    endfunction

    task automatic model_step(input logic [31:0] instr, output logic e_wen, output logic [4:0] e_widx,
                              output logic [31:0] e_wdata, output logic e_ill);
        logic [31:0] a, b, sx, nxt;
        logic [5:0]  op, fn;
        op = instr[31:26];
        fn = instr[5:0];
        a  = m_rd(instr[25:21]);
        b  = m_rd(instr[20:16]);
        sx = {{16{instr[15]}}, instr[15:0]};
        e_wen = 1'b0; e_widx = instr[15:11]; e_wdata = 32'd0; e_ill = 1'b0;
        nxt = m_pc + 32'd4;
        case (op)
            6'h00: case (fn)
                6'h20: begin e_wen = 1'b1; e_wdata = a + b; end
                6'h22: begin e_wen = 1'b1; e_wdata = a - b; end
                6'h24: begin e_wen = 1'b1; e_wdata = a & b; end
                6'h25: begin e_wen = 1'b1; e_wdata = a | b; end
                6'h2A: begin e_wen = 1'b1; e_wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h08: nxt = a & 32'hFFFF_FFFC;
                default: e_ill = 1'b1;
            endcase
            6'h08: begin e_wen = 1'b1; e_widx = instr[20:16]; e_wdata = a + sx; end
            6'h04: if (a == b) nxt = m_pc + 32'd4 + (sx << 2);
            6'h05: if (a != b) nxt = m_pc + 32'd4 + (sx << 2);
            default: e_ill = 1'b1;
        endcase
        if (e_wen && e_widx != 5'd0) m_regs[e_widx] = e_wdata;
        m_pc = nxt;
    endtask

    // Called at a negedge with the core in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input logic [31:0] instr, input int stall,
                             output logic [31:0] o_wdata, output logic o_wen, output logic [4:0] o_widx,
                             output logic o_ill, output logic [31:0] o_next);
        logic [31:0] addr0, pc0, e_wdata;
        logic        e_wen, e_ill;
        logic [4:0]  e_widx;
        int          lat;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        addr0 = imem_addr;
        pc0   = m_pc;
        for (int i = 0; i < stall; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, addr0);
            check("stall_noretire", retire, 0);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        check("exec_noretire", retire, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!retire && lat < 8);
        check("retire_latency", lat, 1);
        o_wdata = retire_wdata;
        o_wen   = retire_wen;
        o_widx  = retire_widx;
        o_ill   = illegal;
        model_step(instr, e_wen, e_widx, e_wdata, e_ill);
        check("model_retire_pc", retire_pc, pc0);
        check("model_wen", retire_wen, e_wen);
        check("model_illegal", illegal, e_ill);
        if (e_wen) begin
            check("model_widx", retire_widx, e_widx);
            check("model_wdata", retire_wdata, e_wdata);
        end
        @(negedge clk);
        check("retire_one_cycle", retire, 0);
        check("model_next_pc", imem_addr, m_pc);
        o_next = imem_addr;
    endtask

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic        wen;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic        ill;
        logic [31:0] next_pc;
    } vec_t;

    vec_t vecs [20];

    // NREGS=8 instance runs a fixed program from RESET_PC=0x40
    logic [31:0] prog8 [6];
    logic [31:0] q8_wdata [$];
    logic [31:0] q8_pc [$];

    always_comb begin
        imem_valid8 = 1'b1;
        imem_rdata8 = 32'd0;
        if (imem_addr8 >= 32'h40 && imem_addr8 < 32'h58) imem_rdata8 = prog8[(imem_addr8 - 32'h40) >> 2];
    end

    always @(negedge clk) begin
        if (!reset && retire8 && q8_wdata.size() < 8) begin
            q8_wdata.push_back(retire_wdata8);
            q8_pc.push_back(retire_pc8);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, nx;
        logic        we, il;
        logic [4:0]  wi;
        logic [31:0] exp8_w [5];
        logic [31:0] exp8_pc [5];

        prog8[0] = itype(6'h08, 0, 9, 16'd7);
        prog8[1] = itype(6'h08, 9, 2, 16'd1);
        prog8[2] = itype(6'h08, 0, 7, 16'd3);
        prog8[3] = rtype(7, 7, 4, 6'h20);
        prog8[4] = rtype(9, 2, 5, 6'h20);
        prog8[5] = itype(6'h04, 0, 0, 16'hFFFF);

        vecs[0]  = '{itype(6'h08, 0, 1, 16'd5),      0, 1, 1,  32'd5,        0, 32'h04};
        vecs[1]  = '{itype(6'h08, 0, 1, 16'hFFFD),   0, 1, 1,  32'hFFFFFFFD, 0, 32'h08};
        vecs[2]  = '{itype(6'h08, 0, 2, 16'd4),      0, 1, 2,  32'd4,        0, 32'h0C};
        vecs[3]  = '{rtype(1, 2, 3, 6'h2A),          0, 1, 3,  32'd1,        0, 32'h10};
        vecs[4]  = '{itype(6'h04, 1, 1, 16'hFFFF),   0, 0, 0,  32'd0,        0, 32'h10};
        vecs[5]  = '{itype(6'h04, 1, 1, 16'd2),      0, 0, 0,  32'd0,        0, 32'h1C};
        vecs[6]  = '{rtype(1, 2, 4, 6'h22),          0, 1, 4,  32'hFFFFFFF9, 0, 32'h20};
        vecs[7]  = '{itype(6'h08, 0, 5, 16'h0010),   0, 1, 5,  32'h10,       0, 32'h24};
        vecs[8]  = '{rtype(5, 0, 0, 6'h08),          0, 0, 0,  32'd0,        0, 32'h10};
        vecs[9]  = '{itype(6'h05, 1, 1, 16'd2),      1, 0, 0,  32'd0,        0, 32'h14};
        vecs[10] = '{itype(6'h08, 0, 5, 16'h0103),   0, 1, 5,  32'h103,      0, 32'h18};
        vecs[11] = '{rtype(5, 0, 0, 6'h08),          0, 0, 0,  32'd0,        0, 32'h100};
        vecs[12] = '{rtype(1, 1, 0, 6'h20),          0, 1, 0,  32'hFFFFFFFA, 0, 32'h104};
        vecs[13] = '{rtype(0, 0, 6, 6'h20),          0, 1, 6,  32'd0,        0, 32'h108};
        vecs[14] = '{32'hFC00_0000,                  0, 0, 0,  32'd0,        1, 32'h10C};
        vecs[15] = '{itype(6'h08, 1, 7, 16'd0),      4, 1, 7,  32'hFFFFFFFD, 0, 32'h110};
        vecs[16] = '{itype(6'h05, 1, 2, 16'hFFFC),   0, 0, 0,  32'd0,        0, 32'h104};
        vecs[17] = '{rtype(1, 2, 8, 6'h24),          2, 1, 8,  32'd4,        0, 32'h108};
        vecs[18] = '{rtype(1, 2, 9, 6'h25),          0, 1, 9,  32'hFFFFFFFD, 0, 32'h10C};
        vecs[19] = '{rtype(1, 2, 10, 6'h21),         0, 0, 0,  32'd0,        1, 32'h110};

        exp8_w  = '{32'd7, 32'd1, 32'd3, 32'd6, 32'd1};
        exp8_pc = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};

        // Reset state
        reset = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_retire", retire, 0);
        check("rst_illegal", illegal, 0);
        check("rst_wen", retire_wen, 0);
        check("rst_widx", retire_widx, 0);
        check("rst_wdata", retire_wdata, 0);
        check("rst_pc", retire_pc, 0);
        check("rst_addr8", imem_addr8, 32'h40);
        reset = 1'b0;
        #1;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            run_instr(vecs[i].instr, vecs[i].stall, w, we, wi, il, nx);
            $display("vec %0d: instr=%08h wen=%0d widx=%0d wdata=%08h ill=%0d next=%08h",
                     i, vecs[i].instr, we, wi, w, il, nx);
            check($sformatf("tbl%0d_wen", i), we, vecs[i].wen);
            check($sformatf("tbl%0d_ill", i), il, vecs[i].ill);
            check($sformatf("tbl%0d_next", i), nx, vecs[i].next_pc);
            if (vecs[i].wen) begin
                check($sformatf("tbl%0d_widx", i), wi, vecs[i].widx);
                check($sformatf("tbl%0d_wdata", i), w, vecs[i].wdata);
            end
        end

        // Randomized program against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ins;
            int k, rs, rt, rd;
            logic [5:0] fns [5];
            logic [5:0] badop [3];
            fns   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            badop = '{6'h3F, 6'h23, 6'h02};
            k  = $urandom_range(0, 9);
            rs = $urandom_range(0, 31);
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom_range(0, 31);
            rd = $urandom_range(0, 31);
            case (k)
                0, 1, 2, 3, 4: ins = rtype(rs, rt, rd, fns[k]);
                5, 6:          ins = itype(6'h08, rs, rt, 16'($urandom));
                7:             ins = itype($urandom_range(0, 1) ? 6'h04 : 6'h05, rs, rt,
                                           16'($urandom_range(0, 16) - 8));
                8:             ins = rtype(rs, 0, 0, 6'h08);
                default:       ins = {badop[$urandom_range(0, 2)], 26'($urandom)};
            endcase
            run_instr(ins, $urandom_range(0, 2), w, we, wi, il, nx);
            $display("rnd %0d: instr=%08h wen=%0d widx=%0d wdata=%08h ill=%0d next=%08h",
                     n, ins, we, wi, w, il, nx);
        end

        // Reset asserted during EXEC abandons the instruction
        imem_valid = 1'b1;
        imem_rdata = itype(6'h08, 0, 10, 16'h0055);
        @(negedge clk);
        imem_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("exec_rst_retire", retire, 0);
        check("exec_rst_req", imem_req, 0);
        check("exec_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("exec_rst_retire_hold", retire, 0);
        reset = 1'b0;
        model_reset();
        #1;
        run_instr(rtype(10, 1, 11, 6'h20), 0, w, we, wi, il, nx);
        $display("post-reset: instr=ADD $11,$10,$1 wdata=%08h next=%08h", w, nx);
        check("post_rst_wdata", w, 32'd0);

        // NREGS=8 instance: writes to $9 discarded, reads of $9 return 0
        check("dut8_count", (q8_wdata.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5 && i < q8_wdata.size(); i++) begin
            $display("dut8 retire %0d: pc=%08h wdata=%08h", i, q8_pc[i], q8_wdata[i]);
            check($sformatf("dut8_wdata%0d", i), q8_wdata[i], exp8_w[i]);
            check($sformatf("dut8_pc%0d", i), q8_pc[i], exp8_pc[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
